sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter and sequencer for the single shared SRAM controller port. It lets the instruction-fetch path and the data cache controller share one 64-bit-read SRAM controller. It accepts one transaction at a time, latches the winning request, drives the controller until its done pulse, and returns the 64-bit read line or write completion to the owning requester. It sits between those requesters and the SRAM controller.

## Interface
- `ADDR_W`, 32, address width of both requesters and the controller.
- `clk`  in  1  system clock, single domain.
- `rst`  in  1  synchronous, active-high reset.
- `i_rd_en`  in  1  instruction port read request; read-only port.
- `i_addr`  in  ADDR_W  instruction port address.
- `i_ready`  out  1  one-cycle completion pulse to the instruction port.
- `i_rdata`  out  64  instruction read data; valid while `i_ready`=1.
- `d_rd_en`  in  1  data port read request.
- `d_wr_en`  in  1  data port write request.
- `d_addr`  in  ADDR_W  data port address.
- `d_wdata`  in  32  data port write data.
- `d_ready`  out  1  one-cycle completion pulse to the data port.
- `d_rdata`  out  64  data read data; valid while `d_ready`=1.
- `sram_rd_en`  out  1  read enable to the SRAM controller.
- `sram_wr_en`  out  1  write enable to the SRAM controller.
- `sram_addr`  out  ADDR_W  address to the controller.
- `sram_wdata`  out  32  write data to the controller.
- `sram_ready`  in  1  one-cycle done pulse from the controller.
- `sram_rdata`  in  64  controller read data; valid with `sram_ready`.
- `busy`  out  1  high in BUSY and RESP; usable as freeze qualifier.

## Operation
- States: IDLE, BUSY, RESP. Registers: `owner` (I/D), `last_owner`, latched op, latched addr, latched wdata, `rdata_q`.
- IDLE:
  - Sample `i_rd_en`, `d_rd_en | d_wr_en`.
  - Single requester: grant it.
  - Both requesting: arbitration per Configuration.
  - On grant, latch addr/wdata/op and set `owner`. Next state is BUSY.
  - No request: stay in IDLE.
- Data port with both `d_rd_en` and `d_wr_en` high: treated as write.
- BUSY:
  - `sram_rd_en`/`sram_wr_en` held at the latched op, `sram_addr`/`sram_wdata` held at the latched values.
  - Requester inputs are ignored; a change of request inputs mid-transaction has no effect.
  - On `sram_ready`=1: capture `sram_rdata` into `rdata_q`, drop the enables, set `last_owner`=`owner`, go to RESP.
- RESP:
  - Assert `i_ready` or `d_ready` per `owner`; the matching rdata output = `rdata_q`.
  - Next state is IDLE unconditionally.
  - Requesters must deassert or change their request by the following cycle; a still-held request is re-arbitrated as a new transaction.
- Write transactions return `d_ready` with `d_rdata` = captured `sram_rdata`; requesters treat it as don't-care.
- Non-owner ready is 0 at all times. Rdata outputs hold `rdata_q` outside RESP.
- Reset:
  - Takes effect at the next `clk` edge with `rst`=1. State=IDLE, `last_owner`=D, `rdata_q`=0.
  - All outputs 0: `busy`, `i_ready`, `d_ready`, `sram_rd_en`, `sram_wr_en`, `sram_addr`, `sram_wdata`, `i_rdata`, `d_rdata`.
  - Reset mid-BUSY abandons the transaction with no ready pulse. The SRAM controller shares `rst`.
- `sram_ready` outside BUSY is ignored.

## Timing
- All outputs are registered; none combinational from inputs.
- Request high in IDLE at cycle N → `sram_*_en` high from N+1.
- `sram_ready` at cycle M → enables low and requester ready at M+1 → IDLE at M+2.
- Minimum transaction: request to ready is (controller latency + 2) cycles. Back-to-back issue interval = controller latency + 3.
- `busy` is high from N+1 through M+1 inclusive.

## Configuration
- Macro: `SRAM_ARB_ROUND_ROBIN_EN`.
- Defined: on a simultaneous request, grant the port ≠ `last_owner`. After reset (`last_owner`=D), the first tie goes to I.
- Undefined: fixed priority, data port always wins ties, because a data stall freezes the whole pipeline. `last_owner` is still maintained but unused for the decision.

## Test plan
- Reset: hold `rst` 2 cycles mid-BUSY, then release. All outputs 0, state IDLE, no ready pulse, next request served normally.
- Single read: `i_rd_en`, `i_addr`=0x40, controller answers 3 cycles after enable with `sram_rdata`=0x1122334455667788. `i_ready` is a single pulse with `i_rdata`=0x1122334455667788; `d_ready` stays 0.
- Data write: `d_wr_en`, `d_addr`=0x400, `d_wdata`=0xDEADBEEF. Enable high with stable addr/wdata until `sram_ready`, then `d_ready` pulse.
- Tie with macro defined: both request continuously for 4 transactions. Grant order I, D, I, D.
- Tie with macro undefined: same stimulus. Grant order D, D, D, D while `d_*` stays asserted; I served only once D drops.
- Stability: toggle `i_addr` and `d_wdata` every cycle during BUSY, and pulse `sram_ready` while IDLE. `sram_addr`/`sram_wdata` unchanged, and the stray pulse is ignored.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between the instruction-fetch and data-cache requesters.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating tie-breaks; default build gives the data port fixed priority.
module sram_port_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [63:0]       i_rdata,
   input  logic              d_rd_en,
   input  logic              d_wr_en,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ready,
   output logic [63:0]       d_rdata,
   output logic              sram_rd_en,
   output logic              sram_wr_en,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic              sram_ready,
   input  logic [63:0]       sram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   state_t      state;
   logic        owner;
   logic        last_owner;
   logic        op_wr;
   logic [63:0] rdata_q;

   logic i_req;
   logic d_req;
   logic tie_d;
   logic grant_d;
   logic grant_wr;

   assign i_req = i_rd_en;
   assign d_req = d_rd_en | d_wr_en;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   assign tie_d = (last_owner == OWNER_I);
`else
   // A data stall freezes the whole pipeline, so the data port always wins a tie.
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
   assign tie_d = 1'b1;
`endif

   assign grant_d  = d_req & (~i_req | tie_d);
   assign grant_wr = grant_d & d_wr_en;

   // Both ports read the captured line; only the owner's ready pulse qualifies it.
   assign i_rdata = rdata_q;
   assign d_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWNER_I;
         last_owner <= OWNER_D;
         op_wr      <= 1'b0;
         rdata_q    <= '0;
         busy       <= 1'b0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         sram_rd_en <= 1'b0;
         sram_wr_en <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req | d_req) begin
                  owner      <= grant_d ? OWNER_D : OWNER_I;
                  op_wr      <= grant_wr;
                  sram_addr  <= grant_d ? d_addr : i_addr;
                  sram_wdata <= grant_d ? d_wdata : 32'd0;
                  sram_rd_en <= ~grant_wr;
                  sram_wr_en <= grant_wr;
                  busy       <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (sram_ready) begin
                  rdata_q    <= sram_rdata;
                  sram_rd_en <= 1'b0;
                  sram_wr_en <= 1'b0;
                  last_owner <= owner;
                  i_ready    <= (owner == OWNER_I);
                  d_ready    <= (owner == OWNER_D);
                  state      <= RESP;
               end else begin
                  sram_rd_en <= ~op_wr;
                  sram_wr_en <= op_wr;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy       <= 1'b0;
               sram_rd_en <= 1'b0;
               sram_wr_en <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter; the bench plays the SRAM controller.
// Tie-break expectations follow SRAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rd_en;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [63:0] i_rdata;
   logic        d_rd_en;
   logic        d_wr_en;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [63:0] d_rdata;
   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_ready;
   logic [63:0] sram_rdata;
   logic        busy;

   int checkCount = 0;
   int failCount  = 0;
   logic modelLastD;
   logic expD;

   sram_port_arbiter #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_rd_en    (i_rd_en),
      .i_addr     (i_addr),
      .i_ready    (i_ready),
      .i_rdata    (i_rdata),
      .d_rd_en    (d_rd_en),
      .d_wr_en    (d_wr_en),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_ready    (d_ready),
      .d_rdata    (d_rdata),
      .sram_rd_en (sram_rd_en),
      .sram_wr_en (sram_wr_en),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_ready (sram_ready),
      .sram_rdata (sram_rdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic iRd, input logic [31:0] iA, input logic dRd,
                                input logic dWr, input logic [31:0] dA, input logic [31:0] dW);
      i_rd_en = iRd;
      i_addr  = iA;
      d_rd_en = dRd;
      d_wr_en = dWr;
      d_addr  = dA;
      d_wdata = dW;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput($sformatf("%s_busy", tag), 64'(busy), 64'd0);
      checkOutput($sformatf("%s_i_ready", tag), 64'(i_ready), 64'd0);
      checkOutput($sformatf("%s_d_ready", tag), 64'(d_ready), 64'd0);
      checkOutput($sformatf("%s_rd_en", tag), 64'(sram_rd_en), 64'd0);
      checkOutput($sformatf("%s_wr_en", tag), 64'(sram_wr_en), 64'd0);
      checkOutput($sformatf("%s_addr", tag), 64'(sram_addr), 64'd0);
      checkOutput($sformatf("%s_wdata", tag), 64'(sram_wdata), 64'd0);
      checkOutput($sformatf("%s_i_rdata", tag), i_rdata, 64'd0);
      checkOutput($sformatf("%s_d_rdata", tag), d_rdata, 64'd0);
   endtask

   task automatic waitEnable(input string tag);
      int waited;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!(sram_rd_en || sram_wr_en) && waited < 20);
      checkOutput($sformatf("%s_en_seen", tag), 64'(sram_rd_en | sram_wr_en), 64'd1);
   endtask

   // Serve one transaction: controller answers lat cycles after the enable appears.
   task automatic serveTxn(input string tag, input int lat, input logic [63:0] data,
                           input logic eD, input logic eWr, input logic [31:0] eAddr,
                           input logic [31:0] eWdata, input logic toggle,
                           input logic clrI, input logic clrD);
      waitEnable(tag);
      checkOutput($sformatf("%s_wr_en", tag), 64'(sram_wr_en), 64'(eWr));
      checkOutput($sformatf("%s_rd_en", tag), 64'(sram_rd_en), 64'(!eWr));
      checkOutput($sformatf("%s_addr", tag), 64'(sram_addr), 64'(eAddr));
      checkOutput($sformatf("%s_busy", tag), 64'(busy), 64'd1);
      for (int c = 0; c < lat; c++) begin
         if (toggle) begin
            i_addr  = ~i_addr;
            d_wdata = d_wdata ^ 32'h5A5A_5A5A;
         end
         @(negedge clk);
      end
      checkOutput($sformatf("%s_addr_hold", tag), 64'(sram_addr), 64'(eAddr));
      checkOutput($sformatf("%s_en_hold", tag), 64'({sram_rd_en, sram_wr_en}), 64'({!eWr, eWr}));
      if (eWr)
         checkOutput($sformatf("%s_wdata_hold", tag), 64'(sram_wdata), 64'(eWdata));
      sram_ready = 1'b1;
      sram_rdata = data;
      @(negedge clk);
      sram_ready = 1'b0;
      sram_rdata = 64'hFFFF_0000_FFFF_0000;
      if (clrI) i_rd_en = 1'b0;
      if (clrD) begin
         d_rd_en = 1'b0;
         d_wr_en = 1'b0;
      end
      checkOutput($sformatf("%s_i_ready", tag), 64'(i_ready), 64'(!eD));
      checkOutput($sformatf("%s_d_ready", tag), 64'(d_ready), 64'(eD));
      checkOutput($sformatf("%s_rdata", tag), eD ? d_rdata : i_rdata, data);
      checkOutput($sformatf("%s_en_drop", tag), 64'(sram_rd_en | sram_wr_en), 64'd0);
      checkOutput($sformatf("%s_busy_resp", tag), 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput($sformatf("%s_ready_end", tag), 64'(i_ready | d_ready), 64'd0);
      checkOutput($sformatf("%s_busy_idle", tag), 64'(busy), 64'd0);
      checkOutput($sformatf("%s_rdata_hold", tag), eD ? d_rdata : i_rdata, data);
   endtask

   initial begin
      rst        = 1'b1;
      sram_ready = 1'b0;
      sram_rdata = 64'd0;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst        = 1'b0;
      modelLastD = 1'b1;

      sram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      sram_ready = 1'b1;
      @(negedge clk);
      sram_ready = 1'b0;
      @(negedge clk);
      checkAllZero("stray_idle");

      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0);
      serveTxn("iread", 3, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 32'h40, 32'd0, 1'b0, 1'b1, 1'b0);
      modelLastD = 1'b0;

      applyStimulus(1'b0, 32'h1234, 1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF);
      serveTxn("dwrite", 4, 64'h0BAD_F00D_0000_0001, 1'b1, 1'b1, 32'h400, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
      modelLastD = 1'b1;

      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h480, 32'h0000_CAFE);
      serveTxn("drdwr", 1, 64'h5555_AAAA_5555_AAAA, 1'b1, 1'b1, 32'h480, 32'h0000_CAFE, 1'b0, 1'b0, 1'b1);
      modelLastD = 1'b1;

      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h800, 32'd0);
      for (int t = 0; t < 4; t++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         expD = !modelLastD;
`else
         expD = 1'b1;
`endif
         serveTxn($sformatf("tie%0d", t), 2, 64'hA000_0000_0000_0000 + 64'(t), expD, 1'b0,
                  expD ? 32'h800 : 32'h100, 32'd0, 1'b0, 1'b0, (t == 3));
         modelLastD = expD;
      end
      serveTxn("tie_after", 2, 64'hB000_0000_0000_0005, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 1'b0);
      modelLastD = 1'b0;

      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h900, 32'd0);
      waitEnable("abandon");
      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("abandon_ready1", 64'(i_ready | d_ready), 64'd0);
      @(negedge clk);
      checkAllZero("abandon_rst");
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abandon_ready2", 64'(i_ready | d_ready), 64'd0);
      checkOutput("abandon_idle", 64'(busy), 64'd0);

      applyStimulus(1'b1, 32'h2C0, 1'b0, 1'b0, 32'd0, 32'd0);
      serveTxn("post_rst", 1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 32'h2C0, 32'd0, 1'b0, 1'b1, 1'b0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
